// File: rtl/poly_seg_feeder.sv
// poly_seg_feeder: double-buffered segment sequencer for a 5th-order polynomial evaluator (option: POLY_SEG_FEEDER_UNDERRUN_CNT_EN)
module poly_seg_feeder #(
   parameter int BC = 8,
   parameter int BT = 8,
   parameter int BN = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [BC-1:0] s_c0,
   input  logic [BC-1:0] s_c1,
   input  logic [BC-1:0] s_c2,
   input  logic [BC-1:0] s_c3,
   input  logic [BC-1:0] s_c4,
   input  logic [BC-1:0] s_c5,
   input  logic [BN-1:0] s_len,
   input  logic [BT-1:0] s_dt,
   output logic [BT-1:0] t_out,
   output logic [BC-1:0] c0_out,
   output logic [BC-1:0] c1_out,
   output logic [BC-1:0] c2_out,
   output logic [BC-1:0] c3_out,
   output logic [BC-1:0] c4_out,
   output logic [BC-1:0] c5_out,
   output logic          out_valid,
   output logic          seg_last,
   output logic          busy,
   output logic [15:0]   underrun_cnt
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t          r_state;
   logic [6*BC-1:0] r_c, r_n_c, w_s_c, w_src_c;
   logic [BN-1:0]   r_rem, r_n_len, w_src_len;
   logic [BT-1:0]   r_dt, r_n_dt, r_t, w_src_dt;
   logic            r_last, r_nxt_full;
   logic            w_load, w_acc, w_take, w_byp, w_src_vld, w_start;
   assign w_s_c     = {s_c5, s_c4, s_c3, s_c2, s_c1, s_c0};
   assign w_load    = (r_state == IDLE) || r_last;
   assign s_ready   = !rst && (!r_nxt_full || w_load);
   assign w_acc     = s_valid && s_ready;
   assign w_take    = w_load && r_nxt_full;
   assign w_byp     = w_load && !r_nxt_full && s_valid;
   assign w_src_vld = w_take || w_byp;
   assign w_src_c   = r_nxt_full ? r_n_c : w_s_c;
   assign w_src_len = r_nxt_full ? r_n_len : s_len;
   assign w_src_dt  = r_nxt_full ? r_n_dt : s_dt;
   // zero-length descriptors are consumed without touching CUR, so outputs hold
   assign w_start   = w_src_vld && (w_src_len != '0);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_c        <= '0;
         r_n_c      <= '0;
         r_rem      <= '0;
         r_n_len    <= '0;
         r_dt       <= '0;
         r_n_dt     <= '0;
         r_t        <= '0;
         r_last     <= 1'b0;
         r_nxt_full <= 1'b0;
      end else begin
         if (w_acc && !w_byp) begin
            r_n_c      <= w_s_c;
            r_n_len    <= s_len;
            r_n_dt     <= s_dt;
            r_nxt_full <= 1'b1;
         end else if (w_take) begin
            r_nxt_full <= 1'b0;
         end
         if (w_load) begin
            r_t     <= '0;
            r_state <= w_start ? RUN : IDLE;
            r_last  <= w_start && (w_src_len == BN'(1));
            if (w_start) begin
               r_c   <= w_src_c;
               r_dt  <= w_src_dt;
               r_rem <= w_src_len - BN'(1);
            end
         end else begin
            r_t    <= r_t + r_dt;
            r_rem  <= r_rem - BN'(1);
            r_last <= (r_rem == BN'(1));
         end
      end
   end
   assign out_valid = (r_state == RUN);
   assign seg_last  = r_last;
   assign t_out     = r_t;
   assign busy      = (r_state == RUN) || r_nxt_full;
   assign c0_out    = r_c[0*BC +: BC];
   assign c1_out    = r_c[1*BC +: BC];
   assign c2_out    = r_c[2*BC +: BC];
   assign c3_out    = r_c[3*BC +: BC];
   assign c4_out    = r_c[4*BC +: BC];
   assign c5_out    = r_c[5*BC +: BC];
`ifdef POLY_SEG_FEEDER_UNDERRUN_CNT_EN
   logic [15:0] r_ucnt;
   logic        w_under;
   assign w_under = r_last && !w_src_vld;
   always_ff @(posedge clk) begin
      if (rst) r_ucnt <= '0;
      else if (w_under && (r_ucnt != 16'hFFFF)) r_ucnt <= r_ucnt + 16'd1;
   end
   assign underrun_cnt = r_ucnt;
`else
   assign underrun_cnt = '0;
`endif
endmodule

// File: tb/tb_poly_seg_feeder.sv
// tb_poly_seg_feeder: table-driven cycle-by-cycle check of poly_seg_feeder plus a mid-segment reset sequence
module tb_poly_seg_feeder;
`ifdef POLY_SEG_FEEDER_UNDERRUN_CNT_EN
   localparam bit UC = 1'b1;
`else
   localparam bit UC = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst, s_valid, s_ready, out_valid, seg_last, busy;
   logic [7:0]  s_c0, s_c1, s_c2, s_c3, s_c4, s_c5, s_dt, t_out;
   logic [7:0]  c0_out, c1_out, c2_out, c3_out, c4_out, c5_out;
   logic [15:0] s_len, underrun_cnt;
   int tests = 0, fails = 0;

   typedef struct {
      bit          v;
      logic [15:0] len;
      logic [7:0]  dt, b;
      bit          ov, last, rdy, bsy;
      logic [7:0]  t, c0;
      logic [15:0] uc;
   } row_t;
   row_t rows[$];

   poly_seg_feeder dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
      .s_c0(s_c0), .s_c1(s_c1), .s_c2(s_c2), .s_c3(s_c3), .s_c4(s_c4), .s_c5(s_c5),
      .s_len(s_len), .s_dt(s_dt), .t_out(t_out),
      .c0_out(c0_out), .c1_out(c1_out), .c2_out(c2_out), .c3_out(c3_out), .c4_out(c4_out), .c5_out(c5_out),
      .out_valid(out_valid), .seg_last(seg_last), .busy(busy), .underrun_cnt(underrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input int r, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s step %0d: got %0h expected %0h", n, r, a, e);
      end
   endtask

   task automatic drv(input bit v, input logic [15:0] len, input logic [7:0] dt, input logic [7:0] b);
      s_valid = v; s_len = len; s_dt = dt;
      s_c0 = b; s_c1 = b + 8'd1; s_c2 = b + 8'd2; s_c3 = b + 8'd3; s_c4 = b + 8'd4; s_c5 = b + 8'd5;
   endtask

   task automatic add(input bit v, input int len, input int dt, input int b, input bit ov, input int t,
                      input bit last, input bit rdy, input bit bsy, input int c0, input int uc);
      row_t r;
      r.v = v; r.len = 16'(len); r.dt = 8'(dt); r.b = 8'(b);
      r.ov = ov; r.t = 8'(t); r.last = last; r.rdy = rdy; r.bsy = bsy; r.c0 = 8'(c0); r.uc = 16'(uc);
      rows.push_back(r);
   endtask

   initial begin
      // single segment len=4 dt=3, coefficients 1..6
      add(1,4,3,1,   0,0,0,1,0,0,0);
      add(0,0,0,0,   1,0,0,1,1,1,0);
      add(0,0,0,0,   1,3,0,1,1,1,0);
      add(0,0,0,0,   1,6,0,1,1,1,0);
      add(0,0,0,0,   1,9,1,1,1,1,0);
      add(0,0,0,0,   0,0,0,1,0,1,1);
      // A len3, B len2 into NXT, D offered while NXT full
      add(1,3,1,10,  0,0,0,1,0,1,1);
      add(1,2,5,20,  1,0,0,1,1,10,1);
      add(1,1,7,30,  1,1,0,0,1,10,1);
      add(1,1,7,30,  1,2,1,1,1,10,1);
      add(0,0,0,0,   1,0,0,0,1,20,1);
      add(0,0,0,0,   1,5,1,1,1,20,1);
      add(0,0,0,0,   1,0,1,1,1,30,1);
      add(0,0,0,0,   0,0,0,1,0,30,2);
      // t wrap with dt=0x80
      add(1,3,128,40,0,0,0,1,0,30,2);
      add(0,0,0,0,   1,0,0,1,1,40,2);
      add(0,0,0,0,   1,128,0,1,1,40,2);
      add(0,0,0,0,   1,0,1,1,1,40,2);
      add(0,0,0,0,   0,0,0,1,0,40,3);
      // zero-length descriptor between two len2 segments
      add(1,2,2,50,  0,0,0,1,0,40,3);
      add(1,0,9,60,  1,0,0,1,1,50,3);
      add(1,2,4,70,  1,2,1,1,1,50,3);
      add(0,0,0,0,   0,0,0,1,1,50,3);
      add(0,0,0,0,   1,0,0,1,1,70,3);
      add(0,0,0,0,   1,4,1,1,1,70,3);
      add(0,0,0,0,   0,0,0,1,0,70,4);
      // underrun then a new descriptor three cycles later
      add(1,2,1,80,  0,0,0,1,0,70,4);
      add(0,0,0,0,   1,0,0,1,1,80,4);
      add(0,0,0,0,   1,1,1,1,1,80,4);
      add(0,0,0,0,   0,0,0,1,0,80,5);
      add(0,0,0,0,   0,0,0,1,0,80,5);
      add(1,1,3,90,  0,0,0,1,0,80,5);
      add(0,0,0,0,   1,0,1,1,1,90,5);
      add(0,0,0,0,   0,0,0,1,0,90,6);

      rst = 1'b1;
      drv(1, 16'd3, 8'd1, 8'h11);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 chk("ready_in_rst", -1, s_ready, 0);
      rst = 1'b0;
      drv(0, 16'd0, 8'd0, 8'd0);
      #1;
      chk("rst_valid", -1, out_valid, 0);
      chk("rst_t", -1, t_out, 0);
      chk("rst_c0", -1, c0_out, 0);
      chk("rst_c5", -1, c5_out, 0);
      chk("rst_busy", -1, busy, 0);
      chk("rst_ucnt", -1, underrun_cnt, 0);

      for (int i = 0; i < rows.size(); i++) begin
         @(negedge clk);
         drv(rows[i].v, rows[i].len, rows[i].dt, rows[i].b);
         #1;
         chk("out_valid", i, out_valid, rows[i].ov);
         chk("t_out", i, t_out, rows[i].t);
         chk("seg_last", i, seg_last, rows[i].last);
         chk("s_ready", i, s_ready, rows[i].rdy);
         chk("busy", i, busy, rows[i].bsy);
         chk("c0_out", i, c0_out, rows[i].c0);
         chk("c3_out", i, c3_out, rows[i].c0 == 0 ? 8'd0 : rows[i].c0 + 8'd3);
         chk("c5_out", i, c5_out, rows[i].c0 == 0 ? 8'd0 : rows[i].c0 + 8'd5);
         chk("underrun_cnt", i, underrun_cnt, UC ? rows[i].uc : 16'd0);
      end

      // reset in the middle of a len=10 segment with NXT holding a descriptor
      @(negedge clk); drv(1, 16'd10, 8'd1, 8'd100);
      @(negedge clk); drv(1, 16'd2, 8'd2, 8'd120);
      @(negedge clk); drv(0, 16'd0, 8'd0, 8'd0);
      #1;
      chk("mid_t", 100, t_out, 1);
      chk("mid_ready", 100, s_ready, 0);
      chk("mid_busy", 100, busy, 1);
      @(negedge clk);
      rst = 1'b1;
      drv(1, 16'd5, 8'd9, 8'd33);
      #1 chk("mid_ready_rst", 101, s_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      drv(0, 16'd0, 8'd0, 8'd0);
      #1;
      chk("post_valid", 102, out_valid, 0);
      chk("post_busy", 102, busy, 0);
      chk("post_t", 102, t_out, 0);
      chk("post_c0", 102, c0_out, 0);
      chk("post_ucnt", 102, underrun_cnt, 0);
      chk("post_ready", 102, s_ready, 1);
      @(negedge clk); drv(1, 16'd2, 8'd6, 8'd5);
      #1 chk("post_idle", 103, out_valid, 0);
      @(negedge clk); drv(0, 16'd0, 8'd0, 8'd0);
      #1;
      chk("new_valid", 104, out_valid, 1);
      chk("new_t0", 104, t_out, 0);
      chk("new_c0", 104, c0_out, 5);
      chk("new_last0", 104, seg_last, 0);
      @(negedge clk);
      #1;
      chk("new_t1", 105, t_out, 6);
      chk("new_last1", 105, seg_last, 1);
      @(negedge clk);
      #1 chk("new_end", 106, out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
